// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller and its buffer.
package imem_fetch_ctrl_pkg;

  localparam int DEPTH_DEFAULT = 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
// DEPTH-entry synchronous FIFO of fetched {pc, instr, fault}; head visible the cycle after push.
// Flush beats push/pop; a push into a full FIFO lands only when a pop happens in the same cycle.
module fetch_buf
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_instr,
  input  logic          push_fault,
  input  logic          pop,
  output logic [31:0]   head_pc,
  output logic [31:0]   head_instr,
  output logic          head_fault,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem [DEPTH];
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_pop;
  logic            do_push;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign wr_entry = '{pc: push_pc, instr: push_instr, fault: push_fault};

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign head_entry = mem[rd_ptr];
  assign head_pc    = head_entry.pc;
  assign head_instr = head_entry.instr;
  assign head_fault = head_entry.fault;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// AXI read-channel instruction fetcher feeding decode through fetch_buf; head is visible 1 cycle after rvalid.
// Commits only while outstanding reads plus buffered entries fit in DEPTH, so decode stalls throttle arvalid.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] axi_imem_araddr,
  output logic        axi_imem_arvalid,
  input  logic        axi_imem_arready,
  input  logic [31:0] axi_imem_rdata,
  input  logic [1:0]  axi_imem_rresp,
  input  logic        axi_imem_rvalid,
  output logic        axi_imem_rready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic [31:0] instructionD,
  output logic [31:0] pcD,
  output logic        instructionD_valid,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state, state_nx;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   ar_addr_q;
  logic [31:0]   redirect_pc_al;
  logic          ar_pend;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard_cnt, discard_nx;
  logic [CW-1:0] buf_count;
  logic [CW:0]   in_use;
  logic [31:0]   head_pc, head_instr;
  logic          head_fault, head_vld;
  logic          rsp_acc, rsp_fault, push, pop, room, new_commit;
  logic          unused_bits;

  assign unused_bits    = &{1'b0, redirect_pc[1:0]};
  assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

  assign rsp_acc   = axi_imem_rvalid && !rst;
  assign rsp_fault = (axi_imem_rresp != RESP_OKAY);
  assign head_vld  = !rst && (buf_count != '0);
  assign pop       = head_vld && dec_ready && !redirect_valid;
  assign push      = rsp_acc && !redirect_valid && (state != ST_DRAIN);

  // Slots still claimed after this cycle: a response in flight just moves from outstanding into the buffer.
  assign in_use     = {1'b0, outstanding} + {1'b0, buf_count} - (CW + 1)'(pop);
  assign room       = in_use < (CW + 1)'(DEPTH);
  assign new_commit = !rst && (state == ST_RUN) && !redirect_valid && !ar_pend && room;

  assign axi_imem_arvalid = !rst && (ar_pend || new_commit);
  assign axi_imem_araddr  = ar_pend ? ar_addr_q : fetch_pc;
  assign axi_imem_rready  = !rst;

  assign instructionD_valid = head_vld;
  assign instructionD       = head_vld ? head_instr : '0;
  assign pcD                = head_vld ? head_pc : '0;
  assign fetch_fault        = head_vld && head_fault;

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (rsp_pc),
    .push_instr (axi_imem_rdata),
    .push_fault (rsp_fault),
    .pop        (pop),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .head_fault (head_fault),
    .count      (buf_count)
  );

  always_comb begin
    state_nx   = state;
    discard_nx = discard_cnt;
    if (redirect_valid) begin
      discard_nx = outstanding - CW'(rsp_acc);
      state_nx   = (discard_nx != '0) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (rsp_acc && rsp_fault) state_nx = ST_FAULT;
        end
        ST_DRAIN: begin
          if (rsp_acc) begin
            discard_nx = discard_cnt - CW'(1);
            if (discard_cnt == CW'(1)) state_nx = ST_RUN;
          end
        end
        ST_FAULT: state_nx = ST_FAULT;
        default:  state_nx = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      ar_pend     <= 1'b0;
      ar_addr_q   <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_nx;
      discard_cnt <= discard_nx;
      outstanding <= outstanding + CW'(new_commit) - CW'(rsp_acc);
      // Responses are in order and every pre-redirect one is dropped, so the kept stream restarts at redirect_pc.
      if (redirect_valid) begin
        fetch_pc <= redirect_pc_al;
        rsp_pc   <= redirect_pc_al;
      end else begin
        if (new_commit) fetch_pc <= fetch_pc + 32'd4;
        if (push)       rsp_pc   <= rsp_pc + 32'd4;
      end
      if (new_commit && !axi_imem_arready) begin
        ar_pend   <= 1'b1;
        ar_addr_q <= fetch_pc;
      end else if (ar_pend && axi_imem_arready) begin
        ar_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed scenarios plus a randomized run against an in-order memory model and a program-order decode model.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] axi_imem_araddr;
  logic        axi_imem_arvalid;
  logic        axi_imem_arready;
  logic [31:0] axi_imem_rdata;
  logic [1:0]  axi_imem_rresp;
  logic        axi_imem_rvalid;
  logic        axi_imem_rready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic [31:0] instructionD;
  logic [31:0] pcD;
  logic        instructionD_valid;
  logic        fetch_fault;

  imem_fetch_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .axi_imem_araddr    (axi_imem_araddr),
    .axi_imem_arvalid   (axi_imem_arvalid),
    .axi_imem_arready   (axi_imem_arready),
    .axi_imem_rdata     (axi_imem_rdata),
    .axi_imem_rresp     (axi_imem_rresp),
    .axi_imem_rvalid    (axi_imem_rvalid),
    .axi_imem_rready    (axi_imem_rready),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .dec_ready          (dec_ready),
    .instructionD       (instructionD),
    .pcD                (pcD),
    .instructionD_valid (instructionD_valid),
    .fetch_fault        (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Stimulus knobs
  bit          rst_i, ar_rdy, dc_rdy, rd_vld, rnd_fault;
  logic [31:0] rd_pc, fault_addr;
  int          lat_min, lat_max;

  // Memory model: accepted addresses and the cycle each response is due
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due;

  // Decode model and per-cycle observations
  logic [31:0] exp_pc;
  int          n_hs, n_pops;
  bit          prev_stall;
  logic [31:0] prev_addr;
  logic        s_arvalid, s_valid, s_fault, s_rready;
  logic [31:0] s_araddr, s_pc, s_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit faultf(input logic [31:0] a);
    return (a == fault_addr) || (rnd_fault && (a[6:2] == 5'd19));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int lat, due;
    @(negedge clk);
    rst              = rst_i;
    axi_imem_arready = ar_rdy;
    dec_ready        = dc_rdy;
    redirect_valid   = rd_vld;
    redirect_pc      = rd_pc;
    if (!rst_i && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      axi_imem_rvalid = 1'b1;
      axi_imem_rdata  = memf(mq_addr[0]);
      axi_imem_rresp  = faultf(mq_addr[0]) ? 2'($urandom_range(1, 3)) : 2'b00;
    end else begin
      axi_imem_rvalid = 1'b0;
      axi_imem_rdata  = $urandom();
      axi_imem_rresp  = 2'($urandom_range(0, 3));
    end
    #1;
    s_arvalid = axi_imem_arvalid;
    s_araddr  = axi_imem_araddr;
    s_valid   = instructionD_valid;
    s_pc      = pcD;
    s_instr   = instructionD;
    s_fault   = fetch_fault;
    s_rready  = axi_imem_rready;
    if (!rst_i) begin
      chk("rready_high", 32'(s_rready), 32'd1);
      chk("inflight_le_depth", 32'(mq_addr.size() <= 2), 32'd1);
      if (prev_stall) begin
        chk("ar_hold_vld", 32'(s_arvalid), 32'd1);
        chk("ar_hold_addr", s_araddr, prev_addr);
      end
      if (s_arvalid) chk("ar_align", 32'(s_araddr[1:0]), 32'd0);
    end
    if (axi_imem_rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (!rst_i && s_arvalid && ar_rdy) begin
      lat = $urandom_range(lat_min, lat_max);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq_addr.push_back(s_araddr);
      mq_due.push_back(due);
      last_due = due;
      n_hs++;
    end
    prev_stall = !rst_i && s_arvalid && !ar_rdy;
    prev_addr  = s_araddr;
    if (!rst_i) begin
      if (rd_vld) begin
        exp_pc = {rd_pc[31:2], 2'b00};
      end else if (s_valid && dc_rdy) begin
        chk("pop_pc", s_pc, exp_pc);
        chk("pop_instr", s_instr, memf(exp_pc));
        chk("pop_fault", 32'(s_fault), 32'(faultf(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        n_pops++;
      end
    end
    @(posedge clk);
    cyc++;
    rd_vld = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rd_vld = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    last_due = -1;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_arvalid", 32'(s_arvalid), 32'd0);
      chk("rst_rready", 32'(s_rready), 32'd0);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_fault", 32'(s_fault), 32'd0);
      chk("rst_instr", s_instr, 32'd0);
      chk("rst_pc", s_pc, 32'd0);
    end
    rst_i = 1'b0;
    exp_pc = 32'h0000_0000;
    prev_stall = 1'b0;
    n_hs = 0;
  endtask

  initial begin
    int k, fault_wait;
    rst = 1'b1; axi_imem_arready = 1'b0; axi_imem_rvalid = 1'b0;
    axi_imem_rdata = '0; axi_imem_rresp = '0; redirect_valid = 1'b0;
    redirect_pc = '0; dec_ready = 1'b0;
    ar_rdy = 1'b1; dc_rdy = 1'b1; rd_vld = 1'b0; rd_pc = '0;
    rnd_fault = 1'b0; fault_addr = 32'h1; lat_min = 1; lat_max = 1;
    n_pops = 0;

    // Reset release, single-cycle memory, back-to-back fetch
    do_reset();
    step(); chk("t1_c0_arvalid", 32'(s_arvalid), 32'd1); chk("t1_c0_araddr", s_araddr, 32'h0);
            chk("t1_c0_novalid", 32'(s_valid), 32'd0);
    step(); chk("t1_c1_araddr", s_araddr, 32'h4); chk("t1_c1_novalid", 32'(s_valid), 32'd0);
    step(); chk("t1_c2_valid", 32'(s_valid), 32'd1); chk("t1_c2_pc", s_pc, 32'h0);
            chk("t1_c2_araddr", s_araddr, 32'h8);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_b2b_arvalid", 32'(s_arvalid), 32'd1);
      chk("t1_b2b_araddr", s_araddr, 32'd12 + 32'(4 * i));
      chk("t1_b2b_valid", 32'(s_valid), 32'd1);
    end

    // Decode stalled: only DEPTH reads commit, arvalid returns with the first pop
    do_reset();
    dc_rdy = 1'b0;
    repeat (10) step();
    chk("t2_reads", 32'(n_hs), 32'd2);
    chk("t2_ar_low", 32'(s_arvalid), 32'd0);
    chk("t2_head_valid", 32'(s_valid), 32'd1);
    chk("t2_head_pc", s_pc, 32'h0);
    dc_rdy = 1'b1;
    step(); chk("t2_resume_arvalid", 32'(s_arvalid), 32'd1); chk("t2_resume_araddr", s_araddr, 32'h8);
    repeat (4) step();

    // Redirect with two reads outstanding
    lat_min = 3; lat_max = 3;
    do_reset();
    step(); step();
    chk("t3_outstanding", 32'(mq_addr.size()), 32'd2);
    rd_vld = 1'b1; rd_pc = 32'h100;
    step();
    step(); chk("t3_drain0_ar", 32'(s_arvalid), 32'd0); chk("t3_drain0_valid", 32'(s_valid), 32'd0);
    step(); chk("t3_drain1_ar", 32'(s_arvalid), 32'd0); chk("t3_drain1_valid", 32'(s_valid), 32'd0);
    step(); chk("t3_restart_ar", 32'(s_arvalid), 32'd1); chk("t3_restart_addr", s_araddr, 32'h100);
    k = 0;
    do begin step(); k++; end while (!s_valid && k < 20);
    chk("t3_first_valid", 32'(s_valid), 32'd1);
    chk("t3_first_pc", s_pc, 32'h100);

    // Redirect coinciding with the only response
    lat_min = 1; lat_max = 1;
    do_reset();
    step();
    rd_vld = 1'b1; rd_pc = 32'h200;
    step();
    step(); chk("t4_run_ar", 32'(s_arvalid), 32'd1); chk("t4_run_addr", s_araddr, 32'h200);
            chk("t4_dropped", 32'(s_valid), 32'd0);
    step();
    step(); chk("t4_first_valid", 32'(s_valid), 32'd1); chk("t4_first_pc", s_pc, 32'h200);

    // Bus error at PC 8
    fault_addr = 32'h8;
    do_reset();
    k = 0;
    do begin step(); k++; end while (!(s_valid && s_fault) && k < 20);
    chk("t5_fault_seen", 32'(s_valid && s_fault), 32'd1);
    chk("t5_fault_pc", s_pc, 32'h8);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_arvalid", 32'(s_arvalid), 32'd0);
    end
    fault_addr = 32'h1;
    rd_vld = 1'b1; rd_pc = 32'h40;
    step();
    step(); chk("t5_restart_ar", 32'(s_arvalid), 32'd1); chk("t5_restart_addr", s_araddr, 32'h40);
    repeat (5) step();

    // Wrap from the top of the address space (low bits of redirect_pc ignored)
    rd_vld = 1'b1; rd_pc = 32'hFFFF_FFFF;
    step();
    step(); chk("t6_top_ar", 32'(s_arvalid), 32'd1); chk("t6_top_addr", s_araddr, 32'hFFFF_FFFC);
    step(); chk("t6_wrap_addr", s_araddr, 32'h0);
    repeat (4) step();

    // Randomized traffic with faults, redirects and a mid-stream reset
    rnd_fault = 1'b1; lat_min = 1; lat_max = 4;
    do_reset();
    n_pops = 0;
    fault_wait = -1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        do_reset();
        fault_wait = -1;
      end
      ar_rdy = ($urandom_range(0, 3) != 0);
      dc_rdy = ($urandom_range(0, 9) < 7);
      if (s_valid && s_fault && fault_wait < 0) fault_wait = $urandom_range(0, 3);
      if (fault_wait == 0 || $urandom_range(0, 49) == 0) begin
        rd_vld = 1'b1;
        rd_pc = $urandom();
        fault_wait = -1;
      end else if (fault_wait > 0) begin
        fault_wait--;
      end
      step();
    end
    chk("rnd_progress", 32'(n_pops > 300), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
